// File: rtl/div_seq_arbiter.sv
// div_seq_arbiter: round-robin front end for one shared radix-2 divider.
// Optional DIV_EARLY_OUT_EN retires |a| < |b| ops in a single cycle.
module div_seq_arbiter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [1:0][1:0]       req_op,
  input  logic [1:0][XLEN-1:0]  req_a,
  input  logic [1:0][XLEN-1:0]  req_b,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic [1:0]            req_ready,
  input  logic                  flush,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [XLEN-1:0]       res_data,
  output logic [TAG_W-1:0]      res_tag,
  output logic                  res_lane,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_nx;

  logic            rr_ptr;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic            is_rem;
  logic            neg_q;
  logic            neg_r;

  logic            sel;
  logic            accept;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            sgn;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            b_zero;
  logic            ovf;
  logic            early;
  logic            special;
  logic [XLEN-1:0] spec_res;

  logic [XLEN:0]   trial;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] fix_q;
  logic [XLEN-1:0] fix_r;
  logic [XLEN-1:0] calc_res;

  // Lane 1 wins when it is the only requester or when it holds the pointer.
  assign sel = req_valid[1] & (~req_valid[0] | rr_ptr);

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !flush) begin
      req_ready[sel] = |req_valid;
    end
  end

  assign accept = |req_ready;
  assign busy   = state != IDLE;

  assign op     = req_op[sel];
  assign a      = req_a[sel];
  assign b      = req_b[sel];
  assign sgn    = ~op[0];
  assign abs_a  = (sgn && a[XLEN-1]) ? -a : a;
  assign abs_b  = (sgn && b[XLEN-1]) ? -b : b;
  assign b_zero = b == '0;
  assign ovf    = sgn && (a == MIN) && (&b);

`ifdef DIV_EARLY_OUT_EN
  assign early = !b_zero && (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  assign special = b_zero | ovf | early;

  always_comb begin
    spec_res = op[1] ? a : '0;
    unique case (1'b1)
      b_zero:  spec_res = op[1] ? a : '1;
      ovf:     spec_res = op[1] ? '0 : MIN;
      default: spec_res = op[1] ? a : '0;
    endcase
  end

  // Restoring step: a borrow out of the trial subtract keeps the old remainder.
  assign trial  = {rem, quo[XLEN-1]} - {1'b0, dvs};
  assign rem_nx = trial[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]}
                              : trial[XLEN-1:0];
  assign quo_nx = {quo[XLEN-2:0], ~trial[XLEN]};

  assign fix_q    = neg_q ? -quo_nx : quo_nx;
  assign fix_r    = neg_r ? -rem_nx : rem_nx;
  assign calc_res = is_rem ? fix_r : fix_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = special ? DONE : CALC;
      end
      CALC: begin
        if (flush)             state_nx = IDLE;
        else if (cnt == LAST)  state_nx = DONE;
      end
      DONE: begin
        if (flush || (res_valid && res_ready)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      cnt       <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      is_rem    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
      res_lane  <= 1'b0;
    end else begin
      state     <= state_nx;
      res_valid <= (state == DONE) && !flush
                   && !(res_valid && res_ready);
      if (accept) begin
        rr_ptr   <= ~sel;
        res_tag  <= req_tag[sel];
        res_lane <= sel;
        is_rem   <= op[1];
        neg_q    <= sgn & (a[XLEN-1] ^ b[XLEN-1]);
        neg_r    <= sgn & a[XLEN-1];
        quo      <= abs_a;
        rem      <= '0;
        dvs      <= abs_b;
        cnt      <= '0;
        if (special) res_data <= spec_res;
      end else if (state == CALC && !flush) begin
        quo <= quo_nx;
        rem <= rem_nx;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) res_data <= calc_res;
      end
    end
  end

endmodule
